// File: rtl/regfile_ctx.sv
// Per-thread register file with predicate bits, two registered read ports, one write port
// and a beat-serial context save/restore engine with valid/ready handshakes.
module regfile_ctx #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int NPRED    = 4,
  parameter int CTX_REGS = 8,
  parameter int CHUNK    = 2,
  localparam int AW      = $clog2(NREGS),
  localparam int PW      = $clog2(NPRED),
  localparam int NBEATS  = CTX_REGS / CHUNK,
  localparam int KW      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           rd_addr0,
  input  logic [AW-1:0]           rd_addr1,
  output logic [DATA_W-1:0]       rd_data0,
  output logic [DATA_W-1:0]       rd_data1,
  input  logic                    wen,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [PW-1:0]           rpred_addr,
  output logic                    rpred_data,
  input  logic                    wpred_en,
  input  logic [PW-1:0]           wpred_addr,
  input  logic                    wpred_data,
  input  logic                    save_req,
  input  logic                    restore_req,
  output logic                    busy,
  output logic                    done,
  output logic                    ctx_out_valid,
  input  logic                    ctx_out_ready,
  output logic [CHUNK*DATA_W-1:0] ctx_out_data,
  output logic                    ctx_out_last,
  input  logic                    ctx_in_valid,
  output logic                    ctx_in_ready,
  input  logic [CHUNK*DATA_W-1:0] ctx_in_data
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [NPRED-1:0]    pred_q;
  logic [DATA_W-1:0]   rd_data0_q;
  logic [DATA_W-1:0]   rd_data1_q;
  logic                rpred_q;
  logic                wr_ok;
  logic                pwr_ok;
  logic                last_beat;

  function automatic logic [AW-1:0] ctx_idx(input logic [KW-1:0] k, input int j);
    return AW'(int'(k) * CHUNK + j);
  endfunction

  assign wr_ok     = wen && (state_q == IDLE);
  assign pwr_ok    = wpred_en && (state_q == IDLE);
  assign last_beat = (k_q == KW'(NBEATS - 1));

  // Control FSM and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          k_q <= '0;
          if (save_req)         state_q <= SAVE;
          else if (restore_req) state_q <= RESTORE;
        end
        SAVE: if (ctx_out_ready) begin
          k_q <= last_beat ? '0 : k_q + 1'b1;
          if (last_beat) state_q <= DONE;
        end
        RESTORE: if (ctx_in_valid) begin
          k_q <= last_beat ? '0 : k_q + 1'b1;
          if (last_beat) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Register array: normal writes in IDLE, unpacked beats during RESTORE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pred_q <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[waddr] <= wdata;
      end else if ((state_q == RESTORE) && ctx_in_valid) begin
        for (int j = 0; j < CHUNK; j++)
          regs_q[ctx_idx(k_q, j)] <= ctx_in_data[(CHUNK-1-j)*DATA_W +: DATA_W];
      end
      if (pwr_ok) pred_q[wpred_addr] <= wpred_data;
    end
  end

  // Registered reads with same-cycle write bypass
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      rpred_q    <= 1'b0;
    end else begin
      rd_data0_q <= (wr_ok && (waddr == rd_addr0)) ? wdata : regs_q[rd_addr0];
      rd_data1_q <= (wr_ok && (waddr == rd_addr1)) ? wdata : regs_q[rd_addr1];
      rpred_q    <= (pwr_ok && (wpred_addr == rpred_addr)) ? wpred_data : pred_q[rpred_addr];
    end
  end

  // Registers cannot change during SAVE, so the beat holds while the sink stalls
  always_comb begin
    ctx_out_data = '0;
    for (int j = 0; j < CHUNK; j++)
      ctx_out_data[(CHUNK-1-j)*DATA_W +: DATA_W] = regs_q[ctx_idx(k_q, j)];
  end

  assign rd_data0      = rd_data0_q;
  assign rd_data1      = rd_data1_q;
  assign rpred_data    = rpred_q;
  assign busy          = (state_q == SAVE) || (state_q == RESTORE);
  assign done          = (state_q == DONE);
  assign ctx_out_valid = (state_q == SAVE);
  assign ctx_out_last  = (state_q == SAVE) && last_beat;
  assign ctx_in_ready  = (state_q == RESTORE);

endmodule
